pattern_detect_ctrl: RTL
========================

// Module: pattern_detect_ctrl
// PURPOSE
// - Configures and sequences a programmable multi-pattern serial detector.
// - Holds NPAT pattern slots, each PAT_W bits wide; shifts in a 1-bit input stream and flags each completed match.
// - Reports the index of the matched slot and counts matches.
// - Sits between the control/config host and the serial bit source; supersedes hard-coded pattern FSMs.
// PARAMETERS
// - NPAT     4  number of pattern slots (>=2)
// - PAT_W    4  pattern length in bits (2..16)
// - CNT_W    8  match counter width; counter saturates
// - OVERLAP  1  1: overlapping matches allowed; 0: window cleared after each match
// PORTS
// - clk          in   1             rising-edge clock
// - rst          in   1             synchronous active-high reset
// - cfg_we       in   1             write slot cfg_idx (accepted only in IDLE)
// - cfg_idx      in   $clog2(NPAT)  slot index for write
// - cfg_pattern  in   PAT_W         pattern value; MSB = first bit received
// - cfg_en       in   1             slot enable written with pattern
// - start        in   1             arm detector (IDLE only)
// - stop         in   1             disarm, return to IDLE
// - in_valid     in   1             qualifies in
// - in           in   1             serial data bit
// - out          out  1             1-cycle match pulse
// - out_pattern  out  $clog2(NPAT)  matched slot index; held until next match
// - match_cnt    out  CNT_W         matches since last start, saturating
// - busy         out  1             1 when not IDLE
// - cfg_err      out  1             1-cycle pulse on rejected cfg_we/start
// BEHAVIOUR
// - Reset: state=IDLE; all slots pattern=0, en=0; window=0; fill=0.
// - Reset: out=0, out_pattern=0, match_cnt=0, busy=0, cfg_err=0.
// - States: IDLE -> FILL -> ARMED.
//   - IDLE: start with >=1 enabled slot -> FILL; clears window, fill counter and match_cnt.
//   - IDLE: start with no enabled slot -> stay IDLE, cfg_err=1.
//   - FILL: each in_valid shifts window={window[PAT_W-2:0],in} and increments fill; fill reaching PAT_W -> ARMED.
//   - ARMED: each in_valid shifts window; compare uses the post-shift window.
//   - stop in FILL/ARMED -> IDLE next cycle; window cleared; match_cnt and out_pattern retained.
// - Match: in ARMED or on the PAT_W-th fill bit, post-shift window == any enabled slot.
//   - out=1 in the cycle after that in_valid sample (1-cycle latency, registered).
//   - Multiple slots hit: lowest index wins for out_pattern.
//   - match_cnt +1, saturating at 2^CNT_W-1.
// - OVERLAP=0: after a match, window and fill cleared; state -> FILL.
// - in_valid=0: no shift, no compare, out=0.
// - cfg_we outside IDLE: ignored, cfg_err=1.
// - cfg_we and start in the same IDLE cycle: write is applied first; start sees the updated enables.
// - start and stop in the same cycle: stop wins (IDLE stays IDLE, no counter clear).
// - start while not IDLE: ignored, no error.
// - rst mid-stream: all state returns to reset values next edge; pending match is not reported.
// STRUCTURE
// - Package pattern_ctrl_pkg: state enum (IDLE/FILL/ARMED) and a clog2-based index-width helper.
// - Sub-module pattern_cmp_bank: combinational compare of window vs NPAT slots plus lowest-index priority encoder.
//   - Outputs: hit and idx.
// - Top module: config registers, shift window, fill counter, FSM, output registers, counter.
// TESTING (NPAT=4, PAT_W=4)
// 1. Program slot0=1011, slot1=0101 (both en); start; stream 0,0,1,0,1,0,1,1,1,1.
//    - out after bit5 (idx1), bit7 (idx1), bit8 (idx0).
//    - match_cnt=3.
// 2. Slot0=slot2=0101 enabled; stream 0,1,0,1 -> single out, out_pattern=0.
// 3. OVERLAP=0, slot1=0101; stream 0,1,0,1,0,1 -> exactly one match at bit4; match_cnt=1.
// 4. cfg_we while ARMED -> cfg_err pulse, slot unchanged.
//    - start with all slots disabled -> cfg_err, busy=0.
// 5. CNT_W=2; stream 1111111 with slot=1111 -> 4 matches reported; match_cnt saturates at 3.
// 6. stop after 2 bits in FILL -> IDLE next cycle, busy=0.
//    - Restart: window empty; first match still requires 4 new bits.
//    - Also: assert rst mid-ARMED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pattern_ctrl_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// controller state encoding and the slot-index width helper.
package pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } state_t;

  // Index width for n slots; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_cmp_bank.sv
// Combinational compare of the shift window against every pattern slot.
// Ports:
//   window - current (post-shift) window, MSB = oldest bit
//   pats   - NPAT slots packed, slot i at [i*PAT_W +: PAT_W]
//   ens    - per-slot enable
//   hit    - some enabled slot equals the window
//   idx    - lowest matching slot index (0 when no hit)
module pattern_cmp_bank
  import pattern_ctrl_pkg::*;
#(
  parameter int NPAT  = 4,
  parameter int PAT_W = 4
) (
  input  logic [PAT_W-1:0]            window,
  input  logic [NPAT*PAT_W-1:0]       pats,
  input  logic [NPAT-1:0]             ens,
  output logic                        hit,
  output logic [idx_width(NPAT)-1:0]  idx
);

  localparam int IDX_W = idx_width(NPAT);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // First hit scanning upward wins, giving lowest-index priority.
    for (int unsigned i = 0; i < NPAT; i++) begin
      if (!hit && ens[i] && (pats[i*PAT_W +: PAT_W] == window)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Programmable multi-pattern serial detector controller.
// Holds NPAT pattern slots of PAT_W bits, shifts in a qualified serial
// stream and emits a registered one-cycle pulse per match, with the index
// of the lowest matching slot and a saturating match counter.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   cfg_we/idx/...   - slot write (pattern + enable), accepted in IDLE only
//   start, stop      - arm / disarm the detector (stop has priority)
//   in_valid, in     - serial input bit and its qualifier
//   out              - one-cycle match pulse
//   out_pattern      - matched slot index, held until the next match
//   match_cnt        - matches since last start, saturating
//   busy             - controller not in IDLE
//   cfg_err          - one-cycle pulse on a rejected cfg_we or start
module pattern_detect_ctrl
  import pattern_ctrl_pkg::*;
#(
  parameter int NPAT    = 4,
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [idx_width(NPAT)-1:0]  cfg_idx,
  input  logic [PAT_W-1:0]            cfg_pattern,
  input  logic                        cfg_en,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        in_valid,
  input  logic                        in,
  output logic                        out,
  output logic [idx_width(NPAT)-1:0]  out_pattern,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        busy,
  output logic                        cfg_err
);

  localparam int IDX_W  = idx_width(NPAT);
  localparam int FILL_W = $clog2(PAT_W + 1);

  state_t                state, state_nxt;
  logic [PAT_W-1:0]      pat_q [NPAT];
  logic [NPAT-1:0]       ens_q;
  logic [NPAT-1:0]       ens_eff;
  logic [NPAT*PAT_W-1:0] pats_flat;
  logic [PAT_W-1:0]      window_q, window_sh;
  logic [FILL_W-1:0]     fill_q, fill_inc;
  logic                  idx_ok;
  logic                  wr, arm, halt, shift, cmp_en, err, match;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;

  assign window_sh = {window_q[PAT_W-2:0], in};
  assign fill_inc  = fill_q + FILL_W'(1);
  assign idx_ok    = (int'(cfg_idx) < NPAT);
  assign busy      = (state != IDLE);

  always_comb begin
    for (int unsigned i = 0; i < NPAT; i++) begin
      pats_flat[i*PAT_W +: PAT_W] = pat_q[i];
    end
  end

  // A write in the same IDLE cycle as start is visible to the start check.
  always_comb begin
    ens_eff = ens_q;
    if (cfg_we && idx_ok) begin
      ens_eff[cfg_idx] = cfg_en;
    end
  end

  pattern_cmp_bank #(
    .NPAT  (NPAT),
    .PAT_W (PAT_W)
  ) u_cmp (
    .window (window_sh),
    .pats   (pats_flat),
    .ens    (ens_q),
    .hit    (hit),
    .idx    (hit_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    arm       = 1'b0;
    halt      = 1'b0;
    shift     = 1'b0;
    cmp_en    = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        wr = cfg_we && idx_ok;
        if (start && !stop) begin
          if (|ens_eff) begin
            state_nxt = FILL;
            arm       = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      FILL: begin
        err = cfg_we;
        if (stop) begin
          state_nxt = IDLE;
          halt      = 1'b1;
        end else if (in_valid) begin
          shift = 1'b1;
          if (fill_inc == FILL_W'(PAT_W)) begin
            cmp_en    = 1'b1;
            state_nxt = ARMED;
          end
        end
      end
      ARMED: begin
        err = cfg_we;
        if (stop) begin
          state_nxt = IDLE;
          halt      = 1'b1;
        end else if (in_valid) begin
          shift  = 1'b1;
          cmp_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    match = cmp_en && hit;
    // Non-overlapping mode restarts the fill after every match.
    if (match && (OVERLAP == 0)) begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPAT; i++) begin
        pat_q[i] <= '0;
      end
      ens_q       <= '0;
      window_q    <= '0;
      fill_q      <= '0;
      out         <= 1'b0;
      out_pattern <= '0;
      match_cnt   <= '0;
      cfg_err     <= 1'b0;
    end else begin
      out     <= match;
      cfg_err <= err;
      if (wr) begin
        pat_q[cfg_idx] <= cfg_pattern;
        ens_q[cfg_idx] <= cfg_en;
      end
      if (arm || halt) begin
        window_q <= '0;
        fill_q   <= '0;
      end else if (shift) begin
        if (match && (OVERLAP == 0)) begin
          window_q <= '0;
          fill_q   <= '0;
        end else begin
          window_q <= window_sh;
          if (state == FILL) begin
            fill_q <= fill_inc;
          end
        end
      end
      if (arm) begin
        match_cnt <= '0;
      end else if (match) begin
        out_pattern <= hit_idx;
        if (match_cnt != '1) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
